// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the CPU
// data port's sram-like interface. Stores 32-bit words with per-byte write
// strobes and answers each request after a programmable latency.
//
// Optional feature: define DMEM_RANDOM_DELAY_EN to add 0..3 extra wait
// cycles per request, drawn from an 8-bit LFSR. Without it the response
// latency is exactly LATENCY cycles.
//
// Handshake: a request is accepted on a rising edge where req & addr_ok;
// addr_ok depends only on the FSM state (high in IDLE). data_ok is a
// single-cycle pulse, and rdata/err are valid during that cycle and hold
// until the next response.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [4:0] LAT5 = 5'(LATENCY);

  state_t              state, state_d;
  logic [4:0]          cnt, cnt_d;
  logic                accept;
  logic [4:0]          extra;
  logic [4:0]          total;

  // Request fields captured at acceptance
  logic                wr_q;
  logic [1:0]          size_q;
  logic [1:0]          off_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [3:0]          wstrb_q;
  logic [31:0]         wdata_q;

  // Fields of the request being answered: live inputs when the response is
  // formed on the acceptance edge itself (zero wait), latched copy otherwise.
  logic                cur_wr;
  logic [1:0]          cur_size;
  logic [1:0]          cur_off;
  logic [ADDR_W-1:0]   cur_idx;
  logic [3:0]          cur_wstrb;
  logic [31:0]         cur_wdata;

  logic [31:0]         mem [0:(1<<ADDR_W)-1];
  logic [31:0]         old_word;
  logic [31:0]         merged;
  logic [31:0]         rdata_d;
  logic                err_d;

  // Address bits above the word index only wrap the memory.
  logic                unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

`ifdef DMEM_RANDOM_DELAY_EN
  logic [7:0] lfsr;

  // Free-running Fibonacci LFSR, taps 8,6,5,4, supplying the extra delay
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= 8'h5A;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign extra = {3'b000, lfsr[1:0]};
`else
  assign extra = 5'd0;
`endif

  assign total     = LAT5 + extra;
  assign addr_ok   = (state == IDLE);
  assign data_ok   = (state == RESP);
  assign state_dbg = state;

  // Byte lanes a well-formed access of the given size/offset may touch.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz,
                                           input logic [1:0] off);
    case (sz)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (total == 5'd1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = total - 5'd2;
          end
        end
      end
      WAIT: begin
        if (cnt == 5'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt - 5'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and wait counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Capture the request at acceptance; held unchanged until the next one
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
    end else if (accept) begin
      wr_q    <= wr;
      size_q  <= size;
      off_q   <= addr[1:0];
      idx_q   <= addr[ADDR_W+1:2];
      wstrb_q <= wstrb;
      wdata_q <= wdata;
    end
  end

  // Select live or latched request fields for the response path
  always_comb begin
    cur_wr    = wr_q;
    cur_size  = size_q;
    cur_off   = off_q;
    cur_idx   = idx_q;
    cur_wstrb = wstrb_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_wr    = wr;
      cur_size  = size;
      cur_off   = addr[1:0];
      cur_idx   = addr[ADDR_W+1:2];
      cur_wstrb = wstrb;
      cur_wdata = wdata;
    end
  end

  assign old_word = mem[cur_idx];

  // Error check and strobe merge for the response word
  always_comb begin
    err_d = 1'b0;
    if (cur_size == 2'b11) err_d = 1'b1;
    if (cur_size == 2'b01 && cur_off[0]) err_d = 1'b1;
    if (cur_size == 2'b10 && cur_off != 2'b00) err_d = 1'b1;
    if (cur_wr && ((cur_wstrb & ~lane_mask(cur_size, cur_off)) != 4'b0000)) err_d = 1'b1;

    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (cur_wstrb[i]) merged[8*i +: 8] = cur_wdata[8*i +: 8];
    end

    rdata_d = (cur_wr && !err_d) ? merged : old_word;
  end

  // rdata/err are loaded on the edge entering RESP so they are valid with data_ok
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= 32'h0;
      err   <= 1'b0;
    end else if (state_d == RESP) begin
      rdata <= rdata_d;
      err   <= err_d;
    end
  end

  // Commit a clean write on the edge leaving RESP; a reset in WAIT/RESP drops it
  always_ff @(posedge clk) begin
    if (state == RESP && wr_q && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data port's sram-like interface. It accepts one request at a time, stores full 32-bit words with per-byte write strobes, and returns whole words after a programmable latency. It sits behind the CPU's load/store formatting logic, which supplies byte-lane strobes and replicated write data and extracts sub-word load results. It is used as the simulation and FPGA data store for functional tests.

## Interface
Parameters:
- ADDR_W, 10: word-address width; memory depth is 2^ADDR_W words.
- LATENCY, 2: cycles from request acceptance to data_ok; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal.
- addr  in  32  byte address.
- wstrb  in  4  byte-lane write enables; bit i controls wdata[8i+7:8i].
- wdata  in  32  write data, already lane-replicated.
- addr_ok  out  1  request accepted when req & addr_ok.
- data_ok  out  1  one-cycle response pulse.
- rdata  out  32  full stored word; registered.
- err  out  1  alignment/strobe error, valid with data_ok.

## Operation
- States are IDLE, WAIT and RESP.
- addr_ok = (state == IDLE), combinational from state only. It does not depend on req.
- **IDLE:**
  - On req & addr_ok, latch wr, size, index = addr[ADDR_W+1:2], addr[1:0], wstrb and wdata.
  - Go to RESP if LATENCY == 1, else go to WAIT with cnt = LATENCY-2.
- **WAIT:** decrement cnt each cycle; at cnt == 0, go to RESP.
- **RESP:**
  - data_ok = 1 and err is valid. Return to IDLE next cycle; addr_ok is 0 in this cycle.
  - Read: rdata <= mem[index].
  - Write with no error: mem[index] byte i <= wdata byte i where wstrb[i]=1. rdata <= the merged new word.
  - Write with error: memory unchanged, rdata <= old word.
- **Error condition (err = 1):**
  - size == 11;
  - size == 01 with addr[0] = 1;
  - size == 10 with addr[1:0] != 00;
  - on a write only: any wstrb bit set outside the lanes selected by size and addr[1:0].
- The byte read path is not checked against strobes.
- wstrb == 0000 on a write is legal: no memory change, data_ok still pulses, err = 0.
- Address bits above ADDR_W+1 are ignored; addresses wrap modulo 2^ADDR_W words.
- Inputs are sampled only at acceptance. Changes to req/addr/wdata while in WAIT or RESP have no effect.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, data_ok 0, err 0, rdata 32'h0. addr_ok is 1 from the first edge after resetn deasserts.
- Acceptance edge is T. data_ok is high exactly during the cycle that follows edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Maximum throughput is one request per LATENCY+1 cycles.
- Read-after-write to the same word returns the new data. The write commits at the RESP edge, before the next acceptance.
- rdata and err hold their values until the next RESP.
- resetn asserted in WAIT or RESP:
  - Immediately returns to IDLE.
  - The pending response is dropped: no data_ok, no memory write.

## Configuration
- Macro: DMEM_RANDOM_DELAY_EN.
- **Defined:**
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded with 8'h5A on reset and advances every cycle.
  - At acceptance, extra = lfsr[1:0] (0..3) is added to the WAIT count. LATENCY==1 with extra != 0 enters WAIT.
  - data_ok then arrives LATENCY+extra cycles after acceptance.
- **Undefined:** no LFSR logic; latency is exactly LATENCY.

## Test plan
- Word write/read:
  - Write addr 0x0000_0010, wstrb 1111, wdata 0xDEADBEEF, then read it → rdata 0xDEADBEEF, err 0.
  - data_ok arrives exactly 2 cycles after each acceptance (default LATENCY).
- Byte merge: after the word write above, write size 00, addr 0x12, wstrb 0100, wdata 0x5A5A5A5A → read of 0x10 returns 0xDE5ABEEF.
- Misalignment:
  - Write size 10, addr 0x16, wstrb 1111 → err 1, and a subsequent read of 0x14 is unchanged.
  - Read size 01, addr 0x13 → err 1.
- Wrap-around: with ADDR_W=10, a write to 0x0000_1004 followed by a read of 0x0000_0004 returns the written data.
- Handshake:
  - With req held high continuously, addr_ok pulses once per 3 cycles and data_ok once per 3 cycles.
  - wdata changed during WAIT does not alter the stored word.
- Reset mid-operation: assert resetn low during WAIT of a write to 0x20 → no data_ok, mem[0x20] unchanged, addr_ok is 1 after release.
